// File: rtl/rv_fpu_csr_file.sv
// Per-warp FP CSR file (fflags/frm/fcsr): supplies frm to FPU issue, accumulates FPU flags, serves CSR accesses.
// Optional per-warp flag-event counter at 0xCC0 enabled by `define FCSR_FLAG_COUNTER_EN.
module rv_fpu_csr_file #(
  parameter int unsigned NUM_WARPS = 4,
  parameter int unsigned NW_BITS   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NW_BITS-1:0]   fpu_read_wid,
  output logic [2:0]           fpu_read_frm,
  input  logic                 fpu_write_enable,
  input  logic [NW_BITS-1:0]   fpu_write_wid,
  input  logic [4:0]           fpu_write_fflags,
  input  logic [NUM_WARPS-1:0] fpu_pending,
  input  logic                 csr_req_valid,
  output logic                 csr_req_ready,
  input  logic [NW_BITS-1:0]   csr_req_wid,
  input  logic [11:0]          csr_req_addr,
  input  logic [1:0]           csr_req_op,
  input  logic [31:0]          csr_req_data,
  output logic                 csr_rsp_valid,
  input  logic                 csr_rsp_ready,
  output logic [31:0]          csr_rsp_data,
  output logic                 csr_rsp_hit,
  output logic [NUM_WARPS-1:0] csr_pending
);

  localparam logic [11:0] ADDR_FFLAGS = 12'h001;
  localparam logic [11:0] ADDR_FRM    = 12'h002;
  localparam logic [11:0] ADDR_FCSR   = 12'h003;
  localparam logic [11:0] ADDR_FCNT   = 12'hCC0;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam int unsigned CNT_W = 16;

  logic [4:0]           r_fflags [NUM_WARPS];
  logic [2:0]           r_frm    [NUM_WARPS];
  logic                 r_rsp_valid;
  logic [31:0]          r_rsp_data;
  logic                 r_rsp_hit;
  logic [NW_BITS-1:0]   r_rsp_wid;
  logic [NUM_WARPS-1:0] r_pending;

  logic [4:0]           w_fflags_nxt [NUM_WARPS];
  logic [2:0]           w_frm_nxt    [NUM_WARPS];
  logic [NUM_WARPS-1:0] w_pending_nxt;
  logic                 w_accept;
  logic                 w_rsp_hs;
  logic                 w_hit;
  logic [31:0]          w_old;
  logic [7:0]           w_new;
  logic                 w_wr_fflags;
  logic                 w_wr_frm;
  logic                 w_unused;

`ifdef FCSR_FLAG_COUNTER_EN
  logic [CNT_W-1:0]     r_flag_cnt [NUM_WARPS];
`endif

  // Operand bits above the widest FP field never reach state.
  assign w_unused = ^csr_req_data[31:8];

  assign csr_req_ready = ~fpu_pending[csr_req_wid] & ~r_pending[csr_req_wid]
                       & (~r_rsp_valid | csr_rsp_ready);
  assign w_accept      = csr_req_valid & csr_req_ready;
  assign w_rsp_hs      = r_rsp_valid & csr_rsp_ready;
  assign fpu_read_frm  = r_frm[fpu_read_wid];

  // Current value of the addressed CSR for the requesting warp.
  always_comb begin
    w_hit = 1'b0;
    w_old = '0;
    case (csr_req_addr)
      ADDR_FFLAGS: begin
        w_hit = 1'b1;
        w_old = {27'd0, r_fflags[csr_req_wid]};
      end
      ADDR_FRM: begin
        w_hit = 1'b1;
        w_old = {29'd0, r_frm[csr_req_wid]};
      end
      ADDR_FCSR: begin
        w_hit = 1'b1;
        w_old = {24'd0, r_frm[csr_req_wid], r_fflags[csr_req_wid]};
      end
`ifdef FCSR_FLAG_COUNTER_EN
      ADDR_FCNT: begin
        w_hit = 1'b1;
        w_old = {16'd0, r_flag_cnt[csr_req_wid]};
      end
`endif
      default: begin
        w_hit = 1'b0;
        w_old = '0;
      end
    endcase
  end

  always_comb begin
    w_new = w_old[7:0];
    case (csr_req_op)
      OP_READ: w_new = w_old[7:0];
      OP_RW:   w_new = csr_req_data[7:0];
      OP_RS:   w_new = w_old[7:0] | csr_req_data[7:0];
      OP_RC:   w_new = w_old[7:0] & ~csr_req_data[7:0];
      default: w_new = w_old[7:0];
    endcase
  end

  assign w_wr_fflags = w_accept & ((csr_req_addr == ADDR_FFLAGS) | (csr_req_addr == ADDR_FCSR));
  assign w_wr_frm    = w_accept & ((csr_req_addr == ADDR_FRM)    | (csr_req_addr == ADDR_FCSR));

  // CSR result lands first, FPU flags are ORed on top so none are lost.
  always_comb begin
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      w_fflags_nxt[w] = r_fflags[w];
      w_frm_nxt[w]    = r_frm[w];
      if (csr_req_wid == NW_BITS'(w)) begin
        if (w_wr_fflags) begin
          w_fflags_nxt[w] = w_new[4:0];
        end
        if (w_wr_frm) begin
          w_frm_nxt[w] = (csr_req_addr == ADDR_FCSR) ? w_new[7:5] : w_new[2:0];
        end
      end
      if (fpu_write_enable && (fpu_write_wid == NW_BITS'(w))) begin
        w_fflags_nxt[w] = w_fflags_nxt[w] | fpu_write_fflags;
      end
    end
  end

  // Response handshake frees the old warp before a new accept marks its own.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_rsp_hs) begin
      w_pending_nxt[r_rsp_wid] = 1'b0;
    end
    if (w_accept) begin
      w_pending_nxt[csr_req_wid] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        r_fflags[w] <= '0;
        r_frm[w]    <= '0;
      end
      r_pending <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        r_fflags[w] <= w_fflags_nxt[w];
        r_frm[w]    <= w_frm_nxt[w];
      end
      r_pending <= w_pending_nxt;
    end
  end

  // Single-entry response register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_hit   <= 1'b0;
      r_rsp_wid   <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_old;
      r_rsp_hit   <= w_hit;
      r_rsp_wid   <= csr_req_wid;
    end else if (w_rsp_hs) begin
      r_rsp_valid <= 1'b0;
    end
  end

`ifdef FCSR_FLAG_COUNTER_EN
  // Saturating count of flag-raising FPU commits per warp; read-only from the CSR side.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        r_flag_cnt[w] <= '0;
      end
    end else begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        if (fpu_write_enable && (fpu_write_wid == NW_BITS'(w)) && (fpu_write_fflags != 5'd0)
            && (r_flag_cnt[w] != {CNT_W{1'b1}})) begin
          r_flag_cnt[w] <= r_flag_cnt[w] + CNT_W'(1);
        end
      end
    end
  end
`endif

  assign csr_rsp_valid = r_rsp_valid;
  assign csr_rsp_data  = r_rsp_data;
  assign csr_rsp_hit   = r_rsp_hit;
  assign csr_pending   = r_pending;

endmodule

// File: tb/tb_rv_fpu_csr_file.sv
// Bench for rv_fpu_csr_file: directed table, corner sequences and random traffic against an fcsr-per-warp model.
module tb_rv_fpu_csr_file;

`ifdef FCSR_FLAG_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  fpu_read_wid;
  logic [2:0]  fpu_read_frm;
  logic        fpu_write_enable;
  logic [1:0]  fpu_write_wid;
  logic [4:0]  fpu_write_fflags;
  logic [3:0]  fpu_pending;
  logic        csr_req_valid;
  logic        csr_req_ready;
  logic [1:0]  csr_req_wid;
  logic [11:0] csr_req_addr;
  logic [1:0]  csr_req_op;
  logic [31:0] csr_req_data;
  logic        csr_rsp_valid;
  logic        csr_rsp_ready;
  logic [31:0] csr_rsp_data;
  logic        csr_rsp_hit;
  logic [3:0]  csr_pending;

  rv_fpu_csr_file #(.NUM_WARPS(4), .NW_BITS(2)) dut (
    .clk(clk), .reset(reset),
    .fpu_read_wid(fpu_read_wid), .fpu_read_frm(fpu_read_frm),
    .fpu_write_enable(fpu_write_enable), .fpu_write_wid(fpu_write_wid),
    .fpu_write_fflags(fpu_write_fflags), .fpu_pending(fpu_pending),
    .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
    .csr_req_wid(csr_req_wid), .csr_req_addr(csr_req_addr),
    .csr_req_op(csr_req_op), .csr_req_data(csr_req_data),
    .csr_rsp_valid(csr_rsp_valid), .csr_rsp_ready(csr_rsp_ready),
    .csr_rsp_data(csr_rsp_data), .csr_rsp_hit(csr_rsp_hit),
    .csr_pending(csr_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Model: one 8-bit fcsr image per warp ({frm,fflags}), plus the response slot.
  logic [7:0]  m_fcsr [4];
  logic [15:0] m_cnt  [4];
  bit          m_rv, m_rhit;
  logic [31:0] m_rdata;
  logic [1:0]  m_rw;
  logic [3:0]  m_pend;
  bit          last_acc;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return !fpu_pending[csr_req_wid] && !m_pend[csr_req_wid] && (!m_rv || csr_rsp_ready);
  endfunction

  function automatic void m_read(input logic [1:0] w, input logic [11:0] a,
                                 output bit hit, output logic [31:0] v);
    hit = 1'b1;
    v   = 32'd0;
    if (a == 12'h001)      v = {27'd0, m_fcsr[w][4:0]};
    else if (a == 12'h002) v = {29'd0, m_fcsr[w][7:5]};
    else if (a == 12'h003) v = {24'd0, m_fcsr[w]};
    else if (a == 12'hCC0 && CNT_EN) v = {16'd0, m_cnt[w]};
    else hit = 1'b0;
  endfunction

  function automatic void m_reset();
    for (int w = 0; w < 4; w++) begin
      m_fcsr[w] = 8'd0;
      m_cnt[w]  = 16'd0;
    end
    m_rv = 0; m_rhit = 0; m_rdata = 0; m_rw = 0; m_pend = 0;
  endfunction

  function automatic void m_edge();
    bit          acc, hs, hit;
    logic [31:0] old;
    logic [7:0]  nv, dd;
    if (reset) begin
      m_reset();
      last_acc = 0;
      return;
    end
    acc = csr_req_valid && m_ready();
    hs  = m_rv && csr_rsp_ready;
    last_acc = acc;
    old = 0; hit = 0;
    if (acc) begin
      m_read(csr_req_wid, csr_req_addr, hit, old);
      dd = csr_req_data[7:0];
      case (csr_req_op)
        2'b01:   nv = dd;
        2'b10:   nv = old[7:0] | dd;
        2'b11:   nv = old[7:0] & ~dd;
        default: nv = old[7:0];
      endcase
      if (csr_req_addr == 12'h001) m_fcsr[csr_req_wid][4:0] = nv[4:0];
      if (csr_req_addr == 12'h002) m_fcsr[csr_req_wid][7:5] = nv[2:0];
      if (csr_req_addr == 12'h003) m_fcsr[csr_req_wid]      = nv;
    end
    if (fpu_write_enable) begin
      m_fcsr[fpu_write_wid][4:0] = m_fcsr[fpu_write_wid][4:0] | fpu_write_fflags;
      if (fpu_write_fflags != 0 && m_cnt[fpu_write_wid] != 16'hFFFF)
        m_cnt[fpu_write_wid] = m_cnt[fpu_write_wid] + 16'd1;
    end
    if (hs) begin
      m_rv = 0;
      m_pend[m_rw] = 1'b0;
    end
    if (acc) begin
      m_rv = 1; m_rdata = old; m_rhit = hit; m_rw = csr_req_wid;
      m_pend[csr_req_wid] = 1'b1;
    end
  endfunction

  // Called at posedge+1 after driving; compares at +2, then advances one edge.
  task automatic tick();
    #1;
    chk("ready", {31'd0, csr_req_ready}, {31'd0, m_ready()});
    chk("read_frm", {29'd0, fpu_read_frm}, {29'd0, m_fcsr[fpu_read_wid][7:5]});
    chk("rsp_valid", {31'd0, csr_rsp_valid}, {31'd0, m_rv});
    chk("pending", {28'd0, csr_pending}, {28'd0, m_pend});
    if (m_rv) begin
      chk("rsp_data", csr_rsp_data, m_rdata);
      chk("rsp_hit", {31'd0, csr_rsp_hit}, {31'd0, m_rhit});
    end
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic accept_req(input logic [1:0] w, input logic [11:0] a,
                            input logic [1:0] op, input logic [31:0] d);
    bit got = 0;
    csr_req_valid = 1; csr_req_wid = w; csr_req_addr = a; csr_req_op = op; csr_req_data = d;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = last_acc;
    end
    csr_req_valid = 0;
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: got no accept expected accept for wid %0d addr 0x%0h", w, a);
    end
  endtask

  task automatic do_req(input logic [1:0] w, input logic [11:0] a, input logic [1:0] op,
                        input logic [31:0] d, output logic [31:0] rd, output logic rh);
    csr_rsp_ready = 1;
    accept_req(w, a, op, d);
    chk("rsp_latency", {31'd0, csr_rsp_valid}, 32'd1);
    rd = csr_rsp_data;
    rh = csr_rsp_hit;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic [1:0]  w;
    logic [11:0] a;
    logic [1:0]  op;
    logic [31:0] d;
    logic [31:0] ed;
    bit          eh;
  } vec_t;

  vec_t        tbl [13];
  logic [31:0] rd, d0;
  logic        rh;
  int          pick;

  initial begin
    reset = 1; fpu_read_wid = 1; fpu_write_enable = 0; fpu_write_wid = 0; fpu_write_fflags = 0;
    fpu_pending = 0; csr_req_valid = 0; csr_req_wid = 0; csr_req_addr = 0; csr_req_op = 0;
    csr_req_data = 0; csr_rsp_ready = 1;
    m_reset();
    last_acc = 0;
    tbl[0]  = '{2'd2, 12'h003, 2'b00, 32'h0,        32'h00, 1'b1};
    tbl[1]  = '{2'd1, 12'h002, 2'b01, 32'h5,        32'h00, 1'b1};
    tbl[2]  = '{2'd1, 12'h002, 2'b00, 32'h0,        32'h05, 1'b1};
    tbl[3]  = '{2'd0, 12'h002, 2'b00, 32'h0,        32'h00, 1'b1};
    tbl[4]  = '{2'd1, 12'h003, 2'b00, 32'h0,        32'hA0, 1'b1};
    tbl[5]  = '{2'd0, 12'h003, 2'b10, 32'h1F,       32'h00, 1'b1};
    tbl[6]  = '{2'd0, 12'h001, 2'b11, 32'h03,       32'h1F, 1'b1};
    tbl[7]  = '{2'd0, 12'h003, 2'b00, 32'h0,        32'h1C, 1'b1};
    tbl[8]  = '{2'd3, 12'h003, 2'b01, 32'hFFFFFFFF, 32'h00, 1'b1};
    tbl[9]  = '{2'd3, 12'h003, 2'b00, 32'h0,        32'hFF, 1'b1};
    tbl[10] = '{2'd1, 12'h300, 2'b01, 32'h55,       32'h00, 1'b0};
    tbl[11] = '{2'd1, 12'h003, 2'b00, 32'h0,        32'hA0, 1'b1};
    tbl[12] = '{2'd2, 12'hCC0, 2'b01, 32'h7,        32'h00, CNT_EN};

    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
    chk("reset_rsp_valid", {31'd0, csr_rsp_valid}, 32'd0);
    chk("reset_rsp_data", csr_rsp_data, 32'd0);
    chk("reset_rsp_hit", {31'd0, csr_rsp_hit}, 32'd0);
    chk("reset_pending", {28'd0, csr_pending}, 32'd0);
    @(posedge clk);
    #1;

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      do_req(tbl[i].w, tbl[i].a, tbl[i].op, tbl[i].d, rd, rh);
      chk($sformatf("tbl%0d_data", i), rd, tbl[i].ed);
      chk($sformatf("tbl%0d_hit", i), {31'd0, rh}, {31'd0, tbl[i].eh});
    end
    idle(2);
    fpu_read_wid = 1; #1;
    chk("frm_w1", {29'd0, fpu_read_frm}, 32'd5);
    fpu_read_wid = 0; #1;
    chk("frm_w0", {29'd0, fpu_read_frm}, 32'd0);
    fpu_read_wid = 1;

    // Reset while a response is stalled.
    csr_rsp_ready = 0;
    accept_req(2'd0, 12'h003, 2'b00, 0);
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("midrst_rsp_valid", {31'd0, csr_rsp_valid}, 32'd0);
    chk("midrst_pending", {28'd0, csr_pending}, 32'd0);
    chk("midrst_rsp_data", csr_rsp_data, 32'd0);
    csr_rsp_ready = 1;
    do_req(2'd1, 12'h002, 2'b00, 0, rd, rh);
    chk("midrst_frm_cleared", rd, 32'd0);

    // Counter: three nonzero flag commits and one zero commit on warp 1.
    fpu_write_enable = 1; fpu_write_wid = 1;
    fpu_write_fflags = 5'h02; tick();
    fpu_write_fflags = 5'h00; tick();
    fpu_write_fflags = 5'h08; tick();
    fpu_write_fflags = 5'h01; tick();
    fpu_write_enable = 0;
    do_req(2'd1, 12'hCC0, 2'b01, 0, rd, rh);
    chk("cnt_data", rd, CNT_EN ? 32'd3 : 32'd0);
    chk("cnt_hit", {31'd0, rh}, {31'd0, CNT_EN});
    do_req(2'd1, 12'hCC0, 2'b00, 0, rd, rh);
    chk("cnt_readonly", rd, CNT_EN ? 32'd3 : 32'd0);

    // Flag accumulate then clear one bit.
    fpu_write_enable = 1; fpu_write_wid = 3;
    fpu_write_fflags = 5'h01; tick();
    fpu_write_fflags = 5'h10; tick();
    fpu_write_enable = 0;
    do_req(2'd3, 12'h001, 2'b11, 32'h01, rd, rh);
    chk("rc_old", rd, 32'h11);
    do_req(2'd3, 12'h001, 2'b00, 0, rd, rh);
    chk("rc_after", rd, 32'h10);

    // FPU pending blocks the request until it drops.
    idle(2);
    fpu_pending = 4'b0001;
    csr_req_valid = 1; csr_req_wid = 0; csr_req_addr = 12'h003; csr_req_op = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("fpu_block_ready", {31'd0, csr_req_ready}, 32'd0);
      #0;
      @(posedge clk); m_edge(); #1;
    end
    fpu_pending = 0;
    tick();
    chk("fpu_unblock_acc", {31'd0, last_acc}, 32'd1);
    csr_req_valid = 0;

    // Same-edge CSR write and FPU accumulate on warp 2.
    idle(2);
    csr_req_valid = 1; csr_req_wid = 2; csr_req_addr = 12'h001; csr_req_op = 2'b01; csr_req_data = 0;
    fpu_write_enable = 1; fpu_write_wid = 2; fpu_write_fflags = 5'h04;
    tick();
    chk("same_edge_acc", {31'd0, last_acc}, 32'd1);
    csr_req_valid = 0; fpu_write_enable = 0;
    do_req(2'd2, 12'h001, 2'b00, 0, rd, rh);
    chk("same_edge_fflags", rd, 32'h04);

    // Stalled response: data holds, no accepts, then back-to-back on another warp.
    idle(2);
    csr_rsp_ready = 0;
    accept_req(2'd1, 12'h003, 2'b00, 0);
    d0 = csr_rsp_data;
    csr_req_valid = 1; csr_req_wid = 2; csr_req_addr = 12'h001; csr_req_op = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data", csr_rsp_data, d0);
      chk("stall_no_acc", {31'd0, last_acc}, 32'd0);
    end
    csr_rsp_ready = 1;
    tick();
    chk("b2b_acc", {31'd0, last_acc}, 32'd1);
    chk("b2b_data", csr_rsp_data, 32'h04);
    csr_req_valid = 0;
    idle(2);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      reset            = ($urandom_range(0, 199) == 0);
      fpu_read_wid     = 2'($urandom_range(0, 3));
      fpu_write_enable = ($urandom_range(0, 2) == 0);
      fpu_write_wid    = 2'($urandom_range(0, 3));
      fpu_write_fflags = 5'($urandom_range(0, 31));
      fpu_pending      = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      csr_req_valid    = ($urandom_range(0, 1) == 1);
      csr_req_wid      = 2'($urandom_range(0, 3));
      pick             = $urandom_range(0, 4);
      csr_req_addr     = (pick == 0) ? 12'h001 : (pick == 1) ? 12'h002 : (pick == 2) ? 12'h003 :
                         (pick == 3) ? 12'hCC0 : 12'($urandom_range(0, 4095));
      csr_req_op       = 2'($urandom_range(0, 3));
      csr_req_data     = $urandom;
      csr_rsp_ready    = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset = 0; csr_req_valid = 0; fpu_write_enable = 0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
